// File: rtl/wide_add_pkg.sv
// Shared types and constants for the wide add/sub sequencer.
package wide_add_pkg;

    localparam int WORD_W    = 16;
    localparam int MAX_WORDS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_state_t;

endpackage

// File: rtl/carry_select_adder_16_bit.sv
// 16-bit carry-select adder: four 4-bit blocks, each precomputed for
// carry-in 0 and 1, with the block carry picking the right result.
module carry_select_adder_16_bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] Sum,
    output logic        Cout
);

    logic [4:0] w_c;

    assign w_c[0] = Cin;

    for (genvar g = 0; g < 4; g++) begin : g_blk
        logic [4:0] w_s0;
        logic [4:0] w_s1;

        assign w_s0 = {1'b0, A[4*g +: 4]} + {1'b0, B[4*g +: 4]};
        assign w_s1 = {1'b0, A[4*g +: 4]} + {1'b0, B[4*g +: 4]} + 5'd1;

        assign Sum[4*g +: 4] = w_c[g] ? w_s1[3:0] : w_s0[3:0];
        assign w_c[g+1]      = w_c[g] ? w_s1[4]   : w_s0[4];
    end

    assign Cout = w_c[4];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle NUM_WORDS x 16-bit add/sub that walks one shared 16-bit
// adder across the operands, least-significant slice first.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter  int NUM_WORDS = 4,
    localparam int W         = WORD_W * NUM_WORDS
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Req_valid,
    output logic         Req_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Sub,
    output logic         Res_valid,
    input  logic         Res_ready,
    output logic [W-1:0] Sum,
    output logic         Cout,
    output logic         Overflow
);

    localparam int KW = $clog2(NUM_WORDS + 1);

    if (NUM_WORDS < 1 || NUM_WORDS > MAX_WORDS) begin : g_bad_words
        $error("wide_add_sequencer: NUM_WORDS out of range");
    end

    add_state_t  r_state;
    logic [KW-1:0] r_k;
    logic        r_carry;
    logic [W-1:0] r_op_a;
    logic [W-1:0] r_op_b;
    logic [W-1:0] r_sum;
    logic        r_cout;
    logic        r_ovf;

    int unsigned       w_idx;
    logic [WORD_W-1:0] w_a;
    logic [WORD_W-1:0] w_b;
    logic [WORD_W-1:0] w_add_sum;
    logic              w_add_cout;
    logic              w_last;
    logic              w_ovf;

    assign w_idx  = WORD_W * int'(r_k);
    assign w_a    = r_op_a[w_idx +: WORD_W];
    assign w_b    = r_op_b[w_idx +: WORD_W];
    assign w_last = (r_k == KW'(NUM_WORDS - 1));

    // Only the top slice's MSBs matter; earlier slices never latch this.
    assign w_ovf = (w_a[WORD_W-1] == w_b[WORD_W-1]) &&
                   (w_add_sum[WORD_W-1] != w_a[WORD_W-1]);

    carry_select_adder_16_bit u_adder (
        .A    (w_a),
        .B    (w_b),
        .Cin  (r_carry),
        .Sum  (w_add_sum),
        .Cout (w_add_cout)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (Req_valid) begin
                        r_op_a  <= A;
                        r_op_b  <= Sub ? ~B : B;
                        r_carry <= Sub;
                        r_k     <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum[w_idx +: WORD_W] <= w_add_sum;
                    r_carry <= w_add_cout;
                    r_k     <= r_k + KW'(1);
                    if (w_last) begin
                        r_cout  <= w_add_cout;
                        r_ovf   <= w_ovf;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (Res_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Req_ready = (r_state == IDLE);
    assign Res_valid = (r_state == DONE);
    assign Sum       = r_sum;
    assign Cout      = r_cout;
    assign Overflow  = r_ovf;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer with NUM_WORDS=4 (64-bit).
module tb_wide_add_sequencer;

    localparam int NW = 4;
    localparam int W  = 16 * NW;

    logic         Clk;
    logic         Reset_n;
    logic         Req_valid;
    logic         Req_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Sub;
    logic         Res_valid;
    logic         Res_ready;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Overflow;

    int total = 0;
    int bad   = 0;

    wide_add_sequencer #(.NUM_WORDS(NW)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Req_valid (Req_valid),
        .Req_ready (Req_ready),
        .A         (A),
        .B         (B),
        .Sub       (Sub),
        .Res_valid (Res_valid),
        .Res_ready (Res_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Overflow  (Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        string        name;
    } vec_t;

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        int n;
        @(negedge Clk);
        A = v.a;
        B = v.b;
        Sub = v.sub;
        Req_valid = 1'b1;
        chk({v.name, " req_ready"}, W'(Req_ready), W'(1));
        @(posedge Clk);
        #1;
        Req_valid = 1'b0;
        A = ~v.a;
        B = ~v.b;
        Sub = ~v.sub;
        n = 0;
        while (!Res_valid && n < 20) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk({v.name, " latency"}, W'(n), W'(NW));
        chk({v.name, " sum"}, Sum, v.sum);
        chk({v.name, " cout"}, W'(Cout), W'(v.cout));
        chk({v.name, " ovf"}, W'(Overflow), W'(v.ovf));
        Res_ready = 1'b1;
        @(posedge Clk);
        #1;
        Res_ready = 1'b0;
        chk({v.name, " valid drop"}, W'(Res_valid), W'(0));
        chk({v.name, " ready rise"}, W'(Req_ready), W'(1));
        chk({v.name, " sum hold"}, Sum, v.sum);
    endtask

    vec_t vecs[7];
    vec_t v;
    logic [W-1:0] held;
    int cnt;

    initial begin
        vecs[0] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0,
                    64'h0000_0000_0001_0000, 1'b0, 1'b0, "carry16"};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                    64'h0, 1'b1, 1'b0, "wrap"};
        vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                    64'h8000_0000_0000_0000, 1'b0, 1'b1, "posovf"};
        vecs[3] = '{64'd5, 64'd7, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, "sub_neg"};
        vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                    64'h2222_2222_2222_2211, 1'b0, 1'b0, "mixed"};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1,
                    64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, "subovf"};
        vecs[6] = '{64'h1234, 64'h1234, 1'b1,
                    64'h0, 1'b1, 1'b0, "sub_eq"};

        Reset_n = 1'b0;
        Req_valid = 1'b0;
        Res_ready = 1'b0;
        A = '0;
        B = '0;
        Sub = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst req_ready", W'(Req_ready), W'(1));
        chk("rst res_valid", W'(Res_valid), W'(0));
        chk("rst sum", Sum, '0);
        chk("rst cout", W'(Cout), W'(0));
        chk("rst ovf", W'(Overflow), W'(0));
        Reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i]);
        end

        // Stall in DONE while inputs churn.
        @(negedge Clk);
        A = 64'h1;
        B = 64'h2;
        Sub = 1'b0;
        Req_valid = 1'b1;
        @(posedge Clk);
        #1;
        Req_valid = 1'b0;
        cnt = 0;
        while (!Res_valid && cnt < 20) begin
            @(posedge Clk);
            #1;
            cnt++;
        end
        chk("stall latency", W'(cnt), W'(NW));
        held = Sum;
        chk("stall sum", held, 64'h3);
        for (int i = 0; i < 10; i++) begin
            A = W'($urandom);
            B = W'($urandom);
            Req_valid = i[0];
            @(posedge Clk);
            #1;
            chk("stall hold", Sum, held);
            chk("stall no accept", W'(Req_ready), W'(0));
            chk("stall valid", W'(Res_valid), W'(1));
        end
        Req_valid = 1'b0;
        Res_ready = 1'b1;
        @(posedge Clk);
        #1;
        Res_ready = 1'b0;
        chk("stall release valid", W'(Res_valid), W'(0));
        chk("stall release ready", W'(Req_ready), W'(1));

        // Res_ready held high in advance: exactly one DONE cycle.
        Res_ready = 1'b1;
        @(negedge Clk);
        A = 64'd10;
        B = 64'd20;
        Sub = 1'b0;
        Req_valid = 1'b1;
        @(posedge Clk);
        #1;
        Req_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clk);
            #1;
            if (Res_valid) begin
                cnt++;
                chk("early ready sum", Sum, 64'd30);
            end
        end
        chk("early ready one done", W'(cnt), W'(1));
        Res_ready = 1'b0;

        // Reset at the second RUN edge aborts the operation.
        @(negedge Clk);
        A = 64'hFFFF;
        B = 64'hFFFF;
        Sub = 1'b0;
        Req_valid = 1'b1;
        @(posedge Clk);
        #1;
        Req_valid = 1'b0;
        @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        chk("abort res_valid", W'(Res_valid), W'(0));
        chk("abort req_ready", W'(Req_ready), W'(1));
        chk("abort sum", Sum, '0);
        chk("abort cout", W'(Cout), W'(0));
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk);
            #1;
            if (Res_valid) cnt++;
        end
        chk("abort no result", W'(cnt), W'(0));

        v = '{64'd3, 64'd4, 1'b0, 64'd7, 1'b0, 1'b0, "post_abort"};
        run_op(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
